// File: rtl/debug_step_controller.sv
// debug_step_controller
// Run/step controller that gates the CPU control-FSM clock enable. It adds a
// debounced step button, multi-step bursts, clock or instruction step
// granularity, a PC breakpoint with resume, and HLT awareness.
//
// Ports
//   clk_1hz          in   system clock (single domain)
//   reset            in   asynchronous, active-low reset
//   mode             in   00 single-step, 01 free run, 10 burst-N, 11 run-to-breakpoint
//   gran             in   0: step unit is one clock, 1: one instruction (ends on instr_done)
//   step_button_raw  in   active-low raw pushbutton
//   step_count       in   burst length for burst mode (0 behaves as 1)
//   bp_addr          in   breakpoint address
//   pc               in   CPU program counter
//   instr_done       in   1-cycle pulse on the last cycle of an instruction
//   halt_in          in   CPU HLT flag (level)
//   fsm_clk_enable   out  CPU clock enable
//   dbg_state        out  00 HALT, 01 RUN, 10 STEP, 11 BREAK
//   steps_remaining  out  units left in the current step/burst
//   bp_hit           out  high while in BREAK
//
// state  | meaning
// HALT   | CPU frozen, waiting for a press or free-run mode
// RUN    | CPU free running (free-run or run-to-breakpoint)
// STEP   | executing the remaining units of a step/burst
// BREAK  | stopped on a breakpoint match, waiting for resume
module debug_step_controller #(
  parameter int ADDR_W     = 12,
  parameter int CNT_W      = 4,
  parameter int DEBOUNCE_N = 2
) (
  input  logic              clk_1hz,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              gran,
  input  logic              step_button_raw,
  input  logic [CNT_W-1:0]  step_count,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc,
  input  logic              instr_done,
  input  logic              halt_in,
  output logic              fsm_clk_enable,
  output logic [1:0]        dbg_state,
  output logic [CNT_W-1:0]  steps_remaining,
  output logic              bp_hit
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_t;

  localparam int DB_W = $clog2(DEBOUNCE_N + 1);

  logic            sync_1, sync_2;
  logic            btn_stable;
  logic [DB_W-1:0] db_cnt;
  logic            press;

  state_t          state, state_n;
  logic [CNT_W-1:0] remaining, remaining_n;
  logic            skip_bp, skip_bp_n;
  logic            unit_done;

  // Synchroniser plus debounce. db_cnt counts consecutive samples that
  // disagree with the accepted level; any agreeing sample restarts it.
  always_ff @(posedge clk_1hz or negedge reset) begin
    if (!reset) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      btn_stable <= 1'b0;
      db_cnt     <= '0;
      press      <= 1'b0;
    end else begin
      sync_1 <= ~step_button_raw;
      sync_2 <= sync_1;
      press  <= 1'b0;
      if (sync_2 == btn_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_N - 1)) begin
        btn_stable <= sync_2;
        db_cnt     <= '0;
        press      <= sync_2;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk_1hz or negedge reset) begin
    if (!reset) begin
      state     <= ST_HALT;
      remaining <= '0;
      skip_bp   <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      skip_bp   <= skip_bp_n;
    end
  end

  assign unit_done = gran ? instr_done : 1'b1;

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    skip_bp_n   = skip_bp;
    if (halt_in) begin
      state_n     = ST_HALT;
      remaining_n = '0;
      skip_bp_n   = 1'b0;
    end else begin
      case (state)
        ST_HALT: begin
          if (mode == 2'b01) begin
            state_n   = ST_RUN;
            skip_bp_n = 1'b0;
          end else if (press) begin
            case (mode)
              2'b00: begin
                state_n     = ST_STEP;
                remaining_n = CNT_W'(1);
              end
              2'b10: begin
                state_n     = ST_STEP;
                remaining_n = (step_count == '0) ? CNT_W'(1) : step_count;
              end
              default: begin
                state_n   = ST_RUN;
                skip_bp_n = 1'b1;
              end
            endcase
          end
        end
        ST_RUN: begin
          // skip_bp only masks the first instruction after a resume
          if (instr_done) skip_bp_n = 1'b0;
          if (mode != 2'b01 && mode != 2'b11) begin
            state_n = ST_HALT;
          end else if (mode == 2'b11 && instr_done && pc == bp_addr && !skip_bp) begin
            state_n = ST_BREAK;
          end
        end
        ST_STEP: begin
          if (unit_done) begin
            if (remaining <= CNT_W'(1)) begin
              state_n     = ST_HALT;
              remaining_n = '0;
            end else begin
              remaining_n = remaining - CNT_W'(1);
            end
          end
        end
        default: begin
          if (press) begin
            state_n   = ST_RUN;
            skip_bp_n = 1'b1;
          end else if (mode == 2'b01) begin
            state_n   = ST_RUN;
            skip_bp_n = 1'b0;
          end else if (mode != 2'b11) begin
            state_n = ST_HALT;
          end
        end
      endcase
    end
  end

  assign fsm_clk_enable  = (state == ST_RUN || state == ST_STEP) && !halt_in;
  assign dbg_state       = state;
  assign steps_remaining = remaining;
  assign bp_hit          = (state == ST_BREAK);

endmodule

// File: tb/tb_debug_step_controller.sv
module tb_debug_step_controller;
  localparam int ADDR_W = 12;
  localparam int CNT_W = 4;
  localparam int DEBOUNCE_N = 2;

  logic              clk_1hz = 1'b0;
  logic              reset;
  logic [1:0]        mode;
  logic              gran;
  logic              step_button_raw;
  logic [CNT_W-1:0]  step_count;
  logic [ADDR_W-1:0] bp_addr;
  logic [ADDR_W-1:0] pc;
  logic              instr_done;
  logic              halt_in;
  logic              fsm_clk_enable;
  logic [1:0]        dbg_state;
  logic [CNT_W-1:0]  steps_remaining;
  logic              bp_hit;

  debug_step_controller #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .DEBOUNCE_N(DEBOUNCE_N)) dut (
    .clk_1hz(clk_1hz), .reset(reset), .mode(mode), .gran(gran),
    .step_button_raw(step_button_raw), .step_count(step_count), .bp_addr(bp_addr),
    .pc(pc), .instr_done(instr_done), .halt_in(halt_in),
    .fsm_clk_enable(fsm_clk_enable), .dbg_state(dbg_state),
    .steps_remaining(steps_remaining), .bp_hit(bp_hit)
  );

  always #5 clk_1hz = ~clk_1hz;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model. Button path: two-sample delay line, then a window of the
  // last DEBOUNCE_N samples; the accepted level flips when the whole window
  // disagrees with it. States use the dbg_state codes: 0 HALT 1 RUN 2 STEP 3 BREAK.
  int m_state, m_rem;
  bit m_skip, m_s1, m_s2, m_stable, m_press;
  bit hist[$];

  task automatic model_reset();
    m_state = 0; m_rem = 0; m_skip = 0;
    m_s1 = 0; m_s2 = 0; m_stable = 0; m_press = 0;
    hist.delete();
  endtask

  task automatic model_edge();
    bit pressed;
    bit all_diff;
    if (!reset) begin
      model_reset();
      return;
    end
    pressed = m_press;
    m_press = 0;
    hist.push_back(m_s2);
    if (hist.size() > DEBOUNCE_N) void'(hist.pop_front());
    if (hist.size() == DEBOUNCE_N) begin
      all_diff = 1;
      foreach (hist[i]) if (hist[i] == m_stable) all_diff = 0;
      if (all_diff) begin
        m_stable = ~m_stable;
        m_press  = m_stable;
      end
    end
    m_s2 = m_s1;
    m_s1 = ~step_button_raw;

    if (halt_in) begin
      m_state = 0; m_rem = 0; m_skip = 0;
    end else if (m_state == 0) begin
      if (mode == 1) begin
        m_state = 1; m_skip = 0;
      end else if (pressed) begin
        if (mode == 0) begin m_state = 2; m_rem = 1; end
        else if (mode == 2) begin m_state = 2; m_rem = (step_count == 0) ? 1 : int'(step_count); end
        else begin m_state = 1; m_skip = 1; end
      end
    end else if (m_state == 1) begin
      bit was_skip = m_skip;
      if (instr_done) m_skip = 0;
      if (mode != 1 && mode != 3) m_state = 0;
      else if (mode == 3 && instr_done && pc == bp_addr && !was_skip) m_state = 3;
    end else if (m_state == 2) begin
      if (gran == 0 || instr_done) begin
        m_rem = m_rem - 1;
        if (m_rem <= 0) begin m_rem = 0; m_state = 0; end
      end
    end else begin
      if (pressed) begin m_state = 1; m_skip = 1; end
      else if (mode == 1) begin m_state = 1; m_skip = 0; end
      else if (mode != 3) m_state = 0;
    end
  endtask

  logic       last_en;
  logic [1:0] last_st;
  logic [CNT_W-1:0] last_rem;

  // Called at a falling edge with inputs already driven.
  task automatic cycle();
    if (!reset) model_reset();
    #1;
    check("dbg_state", dbg_state, m_state);
    check("fsm_clk_enable", fsm_clk_enable, ((m_state == 1 || m_state == 2) && !halt_in) ? 1 : 0);
    check("steps_remaining", steps_remaining, m_rem);
    check("bp_hit", bp_hit, (m_state == 3) ? 1 : 0);
    last_en  = fsm_clk_enable;
    last_st  = dbg_state;
    last_rem = steps_remaining;
    @(posedge clk_1hz);
    model_edge();
    @(negedge clk_1hz);
  endtask

  task automatic idle(input int n);
    mode = 2'b00; step_button_raw = 1'b1; instr_done = 1'b0; halt_in = 1'b0;
    repeat (n) cycle();
  endtask

  int en_cnt, stepc, k;
  int rem_seen[$];
  int btn_t, mode_t;

  initial begin
    reset = 1'b0; mode = 2'b00; gran = 1'b0; step_button_raw = 1'b1;
    step_count = '0; bp_addr = 12'h010; pc = '0; instr_done = 1'b0; halt_in = 1'b0;
    model_reset();
    @(negedge clk_1hz);
    repeat (3) cycle();
    reset = 1'b1;
    idle(3);

    // 1: single step, button held 10 cycles
    en_cnt = 0;
    step_button_raw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) step_button_raw = 1'b1;
      cycle();
      if (last_en) en_cnt++;
    end
    check("t1_enable_pulses", en_cnt, 1);
    check("t1_final_state", last_st, 0);

    // 2: burst of 3, clock granularity
    mode = 2'b10; step_count = 4'd3; gran = 1'b0; en_cnt = 0; rem_seen.delete();
    step_button_raw = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 6) step_button_raw = 1'b1;
      cycle();
      if (last_en) begin en_cnt++; rem_seen.push_back(int'(last_rem)); end
    end
    check("t2_enable_cycles", en_cnt, 3);
    check("t2_rem_count", rem_seen.size(), 3);
    for (int i = 0; i < rem_seen.size(); i++) check("t2_rem_seq", rem_seen[i], 3 - i);
    check("t2_rem_final", last_rem, 0);
    idle(8);

    // 3: single step, instruction granularity, instr_done on 4th STEP cycle
    mode = 2'b00; gran = 1'b1; en_cnt = 0; stepc = 0;
    step_button_raw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 6) step_button_raw = 1'b1;
      instr_done = (dbg_state == 2'b10 && stepc == 3);
      cycle();
      if (last_en) begin en_cnt++; stepc++; end
    end
    instr_done = 1'b0;
    check("t3_enable_cycles", en_cnt, 4);
    check("t3_final_state", last_st, 0);
    gran = 1'b0;
    idle(8);

    // 4: run to breakpoint, then resume past a self-loop at bp_addr
    mode = 2'b11; step_button_raw = 1'b0;
    k = 0;
    while (last_st != 2'b01 && k < 12) begin
      if (k == 6) step_button_raw = 1'b1;
      cycle(); k++;
    end
    check("t4_run_reached", last_st, 1);
    step_button_raw = 1'b1;
    repeat (4) cycle();
    for (int i = 0; i < 3; i++) begin
      pc = 12'h00E + 12'(i); instr_done = 1'b1; cycle();
      instr_done = 1'b0; cycle();
    end
    check("t4_break_state", last_st, 3);
    check("t4_break_enable", last_en, 0);
    step_button_raw = 1'b0;
    k = 0;
    while (last_st != 2'b01 && k < 12) begin cycle(); k++; end
    check("t4_resumed", last_st, 1);
    step_button_raw = 1'b1;
    pc = 12'h010; instr_done = 1'b1; cycle();
    instr_done = 1'b0; repeat (2) cycle();
    check("t4_no_rebreak", last_st, 1);
    idle(8);

    // 5: free run interrupted by halt_in
    mode = 2'b01; repeat (3) cycle();
    check("t5_running", last_en, 1);
    halt_in = 1'b1; cycle();
    check("t5_enable_drop", last_en, 0);
    cycle();
    check("t5_halted", last_st, 0);
    halt_in = 1'b0; repeat (2) cycle();
    check("t5_rerun", last_st, 1);
    idle(8);

    // 6: bouncing button, then held
    mode = 2'b00; en_cnt = 0;
    for (int i = 0; i < 26; i++) begin
      if (i < 6) step_button_raw = i[0];
      else if (i < 16) step_button_raw = 1'b0;
      else step_button_raw = 1'b1;
      cycle();
      if (last_en) en_cnt++;
    end
    check("t6_bounce_steps", en_cnt, 1);
    idle(8);

    // Randomised phase against the model
    btn_t = 0; mode_t = 0;
    for (int i = 0; i < 800; i++) begin
      if (btn_t == 0) begin
        step_button_raw = 1'($urandom_range(0, 1));
        btn_t = $urandom_range(1, 8);
      end else btn_t--;
      if (mode_t == 0) begin
        mode = 2'($urandom_range(0, 3));
        gran = 1'($urandom_range(0, 1));
        step_count = CNT_W'($urandom_range(0, 15));
        mode_t = $urandom_range(1, 20);
      end else mode_t--;
      pc = 12'h00E + 12'($urandom_range(0, 3));
      instr_done = ($urandom_range(0, 2) == 0);
      halt_in = ($urandom_range(0, 15) == 0);
      reset = !($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b1;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
